// File: rtl/ram_dp_be.sv
`default_nettype none
// ============================================================================
// Module      : ram_dp_be
// Description : Word-addressed dual-port RAM for the kanade32 core.
//               Port A: read/write with byte-lane strobes (data side).
//               Port B: read-only (instruction fetch).
//               Request/valid handshake, 1- or 2-cycle read latency,
//               read-first or write-first collision mode, out-of-range flags.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_dp_be #(
    parameter int    DATA_W    = 32,
    parameter int    ADDR_W    = 30,
    parameter int    DEPTH     = 256,
    parameter int    RD_LAT    = 1,
    parameter int    RD_MODE   = 0,
    parameter string INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_req,
    input  logic                a_we,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic [DATA_W-1:0]   a_rdata,
    output logic                a_rvalid,
    output logic                a_err,
    input  logic                b_req,
    input  logic [ADDR_W-1:0]   b_addr,
    output logic [DATA_W-1:0]   b_rdata,
    output logic                b_rvalid,
    output logic                b_err
);

    localparam int              c_lanes = DATA_W / 8;
    localparam int              c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so the range check stays exact even if DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic               w_a_ok;
    logic               w_b_ok;
    logic [c_idx_w-1:0] w_a_idx;
    logic [c_idx_w-1:0] w_b_idx;
    logic               w_a_wr;
    logic               w_a_rd;
    logic               w_coll;
    logic [DATA_W-1:0]  w_b_word;

    // Stage-1 result registers (loaded at the acceptance edge).
    logic               r_a_v1;
    logic               r_a_e1;
    logic [DATA_W-1:0]  r_a_d1;
    logic               r_b_v1;
    logic               r_b_e1;
    logic [DATA_W-1:0]  r_b_d1;

    // Range check uses the full address so high bits never alias into the array.
    assign w_a_ok  = ({1'b0, a_addr} < c_depth);
    assign w_b_ok  = ({1'b0, b_addr} < c_depth);
    assign w_a_idx = a_addr[c_idx_w-1:0];
    assign w_b_idx = b_addr[c_idx_w-1:0];
    assign w_a_wr  = a_req & a_we & w_a_ok;
    assign w_a_rd  = a_req & ~a_we;
    assign w_coll  = w_a_wr & b_req & w_b_ok & (a_addr == b_addr);

    // Port B source word: in write-first mode, splice in the lanes port A is writing now.
    always_comb begin
        w_b_word = r_mem[w_b_idx];
        if (RD_MODE == 1 && w_coll) begin
            for (int i = 0; i < c_lanes; i++) begin
                if (a_be[i]) begin
                    w_b_word[i*8 +: 8] = a_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Byte-lane write into the array; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (w_a_wr) begin
            for (int i = 0; i < c_lanes; i++) begin
                if (a_be[i]) begin
                    r_mem[w_a_idx][i*8 +: 8] <= a_wdata[i*8 +: 8];
                end
            end
        end
    end

    // First read stage: capture array data (old data for reads) and the valid/error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_v1 <= 1'b0;
            r_a_e1 <= 1'b0;
            r_a_d1 <= '0;
            r_b_v1 <= 1'b0;
            r_b_e1 <= 1'b0;
            r_b_d1 <= '0;
        end else begin
            r_a_v1 <= w_a_rd;
            r_a_e1 <= a_req & ~w_a_ok;
            if (w_a_rd) begin
                r_a_d1 <= w_a_ok ? r_mem[w_a_idx] : '0;
            end
            r_b_v1 <= b_req;
            r_b_e1 <= b_req & ~w_b_ok;
            if (b_req) begin
                r_b_d1 <= w_b_ok ? w_b_word : '0;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              r_a_v2;
            logic              r_a_e2;
            logic [DATA_W-1:0] r_a_d2;
            logic              r_b_v2;
            logic              r_b_e2;
            logic [DATA_W-1:0] r_b_d2;

            // Extra output stage; data only advances with a valid result so it holds otherwise.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a_v2 <= 1'b0;
                    r_a_e2 <= 1'b0;
                    r_a_d2 <= '0;
                    r_b_v2 <= 1'b0;
                    r_b_e2 <= 1'b0;
                    r_b_d2 <= '0;
                end else begin
                    r_a_v2 <= r_a_v1;
                    r_a_e2 <= r_a_e1;
                    if (r_a_v1) begin
                        r_a_d2 <= r_a_d1;
                    end
                    r_b_v2 <= r_b_v1;
                    r_b_e2 <= r_b_e1;
                    if (r_b_v1) begin
                        r_b_d2 <= r_b_d1;
                    end
                end
            end

            assign a_rdata  = r_a_d2;
            assign a_rvalid = r_a_v2;
            assign a_err    = r_a_e2;
            assign b_rdata  = r_b_d2;
            assign b_rvalid = r_b_v2;
            assign b_err    = r_b_e2;
        end else begin : g_lat1
            assign a_rdata  = r_a_d1;
            assign a_rvalid = r_a_v1;
            assign a_err    = r_a_e1;
            assign b_rdata  = r_b_d1;
            assign b_rvalid = r_b_v1;
            assign b_err    = r_b_e1;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ram_dp_be.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_dp_be
// Description : Scoreboard bench for ram_dp_be. Two instances share stimulus:
//               dut1 = RD_LAT 1 / read-first, dut2 = RD_LAT 2 / write-first.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_dp_be;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0;
    logic        a_we = 1'b0;
    logic [3:0]  a_be = 4'h0;
    logic [29:0] a_addr = '0;
    logic [31:0] a_wdata = '0;
    logic        b_req = 1'b0;
    logic [29:0] b_addr = '0;

    // Channel map: 0 = dut1.A, 1 = dut1.B, 2 = dut2.A, 3 = dut2.B
    logic [31:0] rd [4];
    logic        rv [4];
    logic        er [4];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    string nm [4];

    typedef struct {
        int          ch;
        logic        rv;
        logic        er;
        logic [31:0] d;
        int          cyc;
    } exp_t;

    exp_t sb [$];

    ram_dp_be #(.DATA_W(32), .ADDR_W(30), .DEPTH(256), .RD_LAT(1), .RD_MODE(0)) dut1 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(rd[0]), .a_rvalid(rv[0]), .a_err(er[0]),
        .b_req(b_req), .b_addr(b_addr),
        .b_rdata(rd[1]), .b_rvalid(rv[1]), .b_err(er[1])
    );

    ram_dp_be #(.DATA_W(32), .ADDR_W(30), .DEPTH(256), .RD_LAT(2), .RD_MODE(1)) dut2 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(rd[2]), .a_rvalid(rv[2]), .a_err(er[2]),
        .b_req(b_req), .b_addr(b_addr),
        .b_rdata(rd[3]), .b_rvalid(rv[3]), .b_err(er[3])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int ch, input logic rv_e, input logic er_e,
                        input logic [31:0] d_e, input int lat);
        exp_t e;
        e.ch  = ch;
        e.rv  = rv_e;
        e.er  = er_e;
        e.d   = d_e;
        e.cyc = cyc + lat;
        sb.push_back(e);
    endtask

    // One cycle of stimulus, driven at a falling edge, with hand-computed expectations.
    // eb0 is the port-B result for read-first, eb1 for write-first.
    task automatic step(input logic ar, input logic aw, input int be, input int aa,
                        input logic [31:0] wd, input logic br, input int ba,
                        input logic [31:0] ea, input logic [31:0] eb0, input logic [31:0] eb1);
        logic aoor;
        logic boor;
        a_req   = ar;
        a_we    = aw;
        a_be    = 4'(be);
        a_addr  = 30'(aa);
        a_wdata = wd;
        b_req   = br;
        b_addr  = 30'(ba);
        aoor    = (aa >= 256);
        boor    = (ba >= 256);
        if (ar && !aw) begin
            push(0, 1'b1, aoor, ea, 1);
            push(2, 1'b1, aoor, ea, 2);
        end else if (ar && aw && aoor) begin
            push(0, 1'b0, 1'b1, 32'h0, 1);
            push(2, 1'b0, 1'b1, 32'h0, 2);
        end
        if (br) begin
            push(1, 1'b1, boor, eb0, 1);
            push(3, 1'b1, boor, eb1, 2);
        end
        @(negedge clk);
    endtask

    task automatic wr(input int aa, input logic [31:0] wd, input int be);
        step(1'b1, 1'b1, be, aa, wd, 1'b0, 0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic rd_a(input int aa, input logic [31:0] ea);
        step(1'b1, 1'b0, 0, aa, 32'h0, 1'b0, 0, ea, 32'h0, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 0, 0, 32'h0, 1'b0, 0, 32'h0, 32'h0, 32'h0);
        end
    endtask

    task automatic dchk(input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", what, act, exp);
        end
    endtask

    task automatic outputs_zero(input string tag);
        dchk({tag, " dut1.a_rdata"}, rd[0], 32'h0);
        dchk({tag, " dut1.b_rdata"}, rd[1], 32'h0);
        dchk({tag, " dut2.a_rdata"}, rd[2], 32'h0);
        dchk({tag, " dut2.b_rdata"}, rd[3], 32'h0);
        dchk({tag, " flags"}, {24'h0, rv[0], rv[1], rv[2], rv[3], er[0], er[1], er[2], er[3]}, 32'h0);
    endtask

    // Monitor: whenever a channel presents a result or error, pop its oldest expectation.
    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (rv[c] === 1'b1 || er[c] === 1'b1) begin
                int   idx;
                exp_t e;
                idx = -1;
                for (int k = 0; k < sb.size(); k++) begin
                    if (idx < 0 && sb[k].ch == c) idx = k;
                end
                checks++;
                if (idx < 0) begin
                    failures++;
                    $display("FAIL %s unexpected output: rvalid=%0b err=%0b data=%h at cycle %0d, required nothing",
                             nm[c], rv[c], er[c], rd[c], cyc);
                end else begin
                    e = sb[idx];
                    sb.delete(idx);
                    if ((rv[c] !== e.rv) || (er[c] !== e.er) ||
                        (e.rv && (rd[c] !== e.d)) || (cyc != e.cyc)) begin
                        failures++;
                        $display("FAIL %s: got rvalid=%0b err=%0b data=%h cycle=%0d, required rvalid=%0b err=%0b data=%h cycle=%0d",
                                 nm[c], rv[c], er[c], rd[c], cyc, e.rv, e.er, e.d, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        nm[0] = "dut1.A";
        nm[1] = "dut1.B";
        nm[2] = "dut2.A";
        nm[3] = "dut2.B";

        repeat (2) @(negedge clk);
        outputs_zero("reset");
        rst = 1'b0;

        // Preload word 0 and read it back (latency 1 vs 2 checked by cycle stamp).
        wr(0, 32'h20080020, 4'hF);
        rd_a(0, 32'h20080020);

        // Byte-lane merge and all-zero strobe no-op.
        wr(5, 32'hFFFFFFFF, 4'hF);
        wr(5, 32'h00000012, 4'h1);
        rd_a(5, 32'hFFFFFF12);
        wr(5, 32'h00000000, 4'h0);
        rd_a(5, 32'hFFFFFF12);

        // Back-to-back reads on both ports, crossed address order.
        wr(1, 32'h01010101, 4'hF);
        wr(2, 32'h02020202, 4'hF);
        wr(3, 32'h03030303, 4'hF);
        step(1'b1, 1'b0, 0, 1, 32'h0, 1'b1, 3, 32'h01010101, 32'h03030303, 32'h03030303);
        step(1'b1, 1'b0, 0, 2, 32'h0, 1'b1, 2, 32'h02020202, 32'h02020202, 32'h02020202);
        step(1'b1, 1'b0, 0, 3, 32'h0, 1'b1, 1, 32'h03030303, 32'h01010101, 32'h01010101);

        // Same-address collision, full word then partial lanes.
        wr(7, 32'h11111111, 4'hF);
        step(1'b1, 1'b1, 4'hF, 7, 32'hDEADBEEF, 1'b1, 7, 32'h0, 32'h11111111, 32'hDEADBEEF);
        step(1'b1, 1'b0, 0, 7, 32'h0, 1'b1, 7, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        step(1'b1, 1'b1, 4'h3, 7, 32'h00000000, 1'b1, 7, 32'h0, 32'hDEADBEEF, 32'hDEAD0000);
        step(1'b0, 1'b0, 0, 0, 32'h0, 1'b1, 7, 32'h0, 32'hDEAD0000, 32'hDEAD0000);

        // Range boundary: last valid word, first invalid word, high address bits.
        wr(255, 32'h000000FF, 4'hF);
        step(1'b1, 1'b0, 0, 255, 32'h0, 1'b1, 255, 32'h000000FF, 32'h000000FF, 32'h000000FF);
        step(1'b1, 1'b0, 0, 256, 32'h0, 1'b1, 256, 32'h0, 32'h0, 32'h0);
        wr(32'h100, 32'hCAFEF00D, 4'hF);
        rd_a(0, 32'h20080020);
        wr(32'h10000000, 32'h55555555, 4'hF);
        step(1'b1, 1'b0, 0, 32'h10000005, 32'h0, 1'b1, 32'h10000000, 32'h0, 32'h0, 32'h0);
        rd_a(5, 32'hFFFFFF12);
        idle(3);

        // Reset while a read is in flight: nothing may emerge afterwards.
        a_req  = 1'b1;
        a_we   = 1'b0;
        a_addr = 30'd0;
        @(posedge clk);
        #1;
        rst   = 1'b1;
        a_req = 1'b0;
        @(negedge clk);
        outputs_zero("midreset");
        rst = 1'b0;
        idle(3);
        outputs_zero("postreset");

        // Array contents survive reset.
        step(1'b1, 1'b0, 0, 0, 32'h0, 1'b1, 5, 32'h20080020, 32'hFFFFFF12, 32'hFFFFFF12);
        idle(4);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard drain: %0d expected results never appeared, required 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
